// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin bus arbiter holding ownership for one bus transaction
// Optional grant timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
    parameter  int NUM_MASTERS    = 4,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int OWNER_W        = $clog2(NUM_MASTERS)
) (
    input  logic                   system_clock,
    input  logic                   system_reset_n,
    input  logic [NUM_MASTERS-1:0] request,
    input  logic                   begin_transactionIN,
    input  logic                   end_transactionIN,
    input  logic                   errorIN,
    output logic [NUM_MASTERS-1:0] granted,
    output logic                   grant_valid,
    output logic [OWNER_W-1:0]     owner_id,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_GRANTED     = 2'd1,
        S_TRANSACTION = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [NUM_MASTERS-1:0]   r_granted;
    logic [NUM_MASTERS-1:0]   w_next_granted;
    logic                     r_grant_valid;
    logic [OWNER_W-1:0]       r_owner;
    logic [OWNER_W-1:0]       w_next_owner;
    logic [OWNER_W-1:0]       w_winner;
    logic [OWNER_W-1:0]       w_cand;
    logic                     w_found;
    logic                     w_timeout_hit;

    // Round-robin search starting one past the current/most recent owner
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_cand = OWNER_W'((int'(r_owner) + i) % NUM_MASTERS);
            if (!w_found && request[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Cycles spent in GRANTED; held at zero everywhere else so entry starts from zero
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_cnt <= '0;
        end else if (r_state != S_GRANTED) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Revoke only when no higher-priority exit (error, begin, abandoned request) applies
    assign w_timeout_hit = (r_state == S_GRANTED) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                           !begin_transactionIN && !errorIN && request[r_owner];

    // One-cycle pulse coinciding with the grant drop
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    // TIMEOUT_CYCLES is always positive, so this is a constant 0
    assign timeout       = (TIMEOUT_CYCLES < 0);
`endif

    // Next state, grant vector and owner; a new grant is only ever issued from IDLE,
    // which forces the single turnaround cycle between grants
    always_comb begin
        w_next_state   = r_state;
        w_next_granted = r_granted;
        w_next_owner   = r_owner;
        case (r_state)
            S_IDLE: begin
                w_next_granted = '0;
                if (w_found) begin
                    w_next_state   = S_GRANTED;
                    w_next_granted = NUM_MASTERS'(1) << w_winner;
                    w_next_owner   = w_winner;
                end
            end
            S_GRANTED: begin
                if (errorIN || (begin_transactionIN && end_transactionIN)) begin
                    w_next_state   = S_IDLE;
                    w_next_granted = '0;
                end else if (begin_transactionIN) begin
                    w_next_state   = S_TRANSACTION;
                end else if (!request[r_owner] || w_timeout_hit) begin
                    w_next_state   = S_IDLE;
                    w_next_granted = '0;
                end
            end
            S_TRANSACTION: begin
                if (end_transactionIN || errorIN) begin
                    w_next_state   = S_IDLE;
                    w_next_granted = '0;
                end
            end
            default: begin
                w_next_state   = S_IDLE;
                w_next_granted = '0;
            end
        endcase
    end

    // State and registered outputs; owner pointer resets so master 0 wins first
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_state       <= S_IDLE;
            r_granted     <= '0;
            r_grant_valid <= 1'b0;
            r_owner       <= OWNER_W'(NUM_MASTERS - 1);
        end else begin
            r_state       <= w_next_state;
            r_granted     <= w_next_granted;
            r_grant_valid <= |w_next_granted;
            r_owner       <= w_next_owner;
        end
    end

    assign granted     = r_granted;
    assign grant_valid = r_grant_valid;
    assign owner_id    = r_owner;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - scoreboard testbench for bus_arbiter_rr
module tb_bus_arbiter_rr;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] request = '0;
    logic         beg = 1'b0;
    logic         en = 1'b0;
    logic         err = 1'b0;
    logic [N-1:0] granted;
    logic         grant_valid;
    logic [1:0]   owner_id;
    logic         timeout;

    int checks = 0;
    int errors = 0;
    int sb[$];
    logic [N-1:0] prev_granted = '0;

    bus_arbiter_rr #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(16)) dut (
        .system_clock        (clk),
        .system_reset_n      (rst_n),
        .request             (request),
        .begin_transactionIN (beg),
        .end_transactionIN   (en),
        .errorIN             (err),
        .granted             (granted),
        .grant_valid         (grant_valid),
        .owner_id            (owner_id),
        .timeout             (timeout)
    );

    always #5 clk = ~clk;

    // Monitor: invariants every cycle, and every new grant popped against the scoreboard
    always @(negedge clk) begin
        int exp_m;
        checks++;
        if (grant_valid !== (|granted) || !$onehot0(granted)) begin
            errors++;
            $display("FAIL invariant: granted=%b grant_valid=%b", granted, grant_valid);
        end
        if (granted !== '0 && granted !== prev_granted) begin
            checks++;
            if (prev_granted !== '0) begin
                errors++;
                $display("FAIL turnaround: prev=%b now=%b required prev=0000", prev_granted, granted);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: granted=%b required none", granted);
            end else begin
                exp_m = sb.pop_front();
                if (granted !== (N'(1) << exp_m) || owner_id !== 2'(exp_m)) begin
                    errors++;
                    $display("FAIL grant_order: granted=%b owner=%0d required master %0d", granted, owner_id, exp_m);
                end
            end
        end
        prev_granted = granted;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        request = '0; beg = 1'b0; en = 1'b0; err = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic close_single_beat();
        request = '0; beg = 1'b1; en = 1'b1;
        tick();
        beg = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset();
        request = '0; beg = 1'b0; en = 1'b0; err = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (granted !== '0 || grant_valid !== 1'b0 || timeout !== 1'b0 || owner_id !== 2'd3) begin
            errors++;
            $display("FAIL reset_state: granted=%b gv=%b to=%b owner=%0d required 0000/0/0/3", granted, grant_valid, timeout, owner_id);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (granted !== '0 || owner_id !== 2'd3) begin
            errors++;
            $display("FAIL reset_release: granted=%b owner=%0d required 0000/3", granted, owner_id);
        end
    endtask

    task automatic test_single();
        do_reset();
        request = 4'b0001;
        sb.push_back(0);
        tick();
        checks++;
        if (granted !== 4'b0001 || owner_id !== 2'd0) begin
            errors++;
            $display("FAIL single_grant: granted=%b owner=%0d required 0001/0", granted, owner_id);
        end
        request = '0; beg = 1'b1;
        tick();
        beg = 1'b0;
        repeat (3) tick();
        checks++;
        if (granted !== 4'b0001) begin
            errors++;
            $display("FAIL single_held: granted=%b required 0001", granted);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (granted !== '0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release: granted=%b gv=%b required 0000/0", granted, grant_valid);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        request = 4'b1111;
        sb.push_back(order[0]);
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (granted !== (N'(1) << order[k])) begin
                errors++;
                $display("FAIL rr_grant[%0d]: granted=%b required master %0d", k, granted, order[k]);
            end
            beg = 1'b1;
            tick();
            beg = 1'b0;
            tick();
            en = 1'b1;
            tick();
            en = 1'b0;
            checks++;
            if (granted !== '0) begin
                errors++;
                $display("FAIL rr_gap[%0d]: granted=%b required 0000", k, granted);
            end
            if (k < 4) sb.push_back(order[k+1]);
            else request = '0;
            tick();
        end
    endtask

    task automatic test_abandon_and_single_beat();
        do_reset();
        request = 4'b0100;
        sb.push_back(2);
        tick();
        checks++;
        if (granted !== 4'b0100 || owner_id !== 2'd2) begin
            errors++;
            $display("FAIL abandon_grant: granted=%b owner=%0d required 0100/2", granted, owner_id);
        end
        request = 4'b1001;
        tick();
        checks++;
        if (granted !== '0) begin
            errors++;
            $display("FAIL abandon_release: granted=%b required 0000", granted);
        end
        sb.push_back(3);
        tick();
        checks++;
        if (granted !== 4'b1000 || owner_id !== 2'd3) begin
            errors++;
            $display("FAIL abandon_next: granted=%b owner=%0d required 1000/3", granted, owner_id);
        end
        close_single_beat();
        checks++;
        if (granted !== '0) begin
            errors++;
            $display("FAIL single_beat_release: granted=%b required 0000", granted);
        end
        tick();
        request = 4'b0010;
        sb.push_back(1);
        tick();
        checks++;
        if (granted !== 4'b0010) begin
            errors++;
            $display("FAIL single_beat_no_hang: granted=%b required 0010", granted);
        end
        close_single_beat();
    endtask

    task automatic test_error();
        do_reset();
        request = 4'b0011;
        sb.push_back(0);
        tick();
        beg = 1'b1; request = 4'b0010;
        tick();
        beg = 1'b0;
        tick();
        err = 1'b1;
        tick();
        err = 1'b0;
        checks++;
        if (granted !== '0) begin
            errors++;
            $display("FAIL error_release: granted=%b required 0000", granted);
        end
        sb.push_back(1);
        tick();
        checks++;
        if (granted !== 4'b0010 || owner_id !== 2'd1) begin
            errors++;
            $display("FAIL error_next: granted=%b owner=%0d required 0010/1", granted, owner_id);
        end
        close_single_beat();
    endtask

    task automatic test_reset_mid();
        do_reset();
        request = 4'b0001;
        sb.push_back(0);
        tick();
        beg = 1'b1; request = '0;
        tick();
        beg = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (granted !== '0 || grant_valid !== 1'b0 || owner_id !== 2'd3) begin
            errors++;
            $display("FAIL reset_mid: granted=%b gv=%b owner=%0d required 0000/0/3", granted, grant_valid, owner_id);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        int held = 0;
        do_reset();
`ifdef BUS_ARB_TIMEOUT_EN
        request = 4'b0011;
        sb.push_back(0);
        tick();
        while (granted !== '0 && held < 40) begin
            tick();
            held++;
        end
        checks++;
        if (held != 16 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_drop: held=%0d timeout=%b required 16/1", held, timeout);
        end
        sb.push_back(1);
        tick();
        checks++;
        if (timeout !== 1'b0 || granted !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_next: timeout=%b granted=%b required 0/0010", timeout, granted);
        end
        close_single_beat();
`else
        request = 4'b0001;
        sb.push_back(0);
        tick();
        repeat (100) begin
            tick();
            if (timeout !== 1'b0) held++;
        end
        checks++;
        if (granted !== 4'b0001 || held != 0) begin
            errors++;
            $display("FAIL no_timeout_hold: granted=%b timeout_cycles=%0d required 0001/0", granted, held);
        end
        close_single_beat();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abandon_and_single_beat();
        test_error();
        test_reset_mid();
        test_timeout();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
